// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Redirect targets are word addresses; the low byte-offset bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_stage_if_id_reg.sv
// IF/ID pipeline register with load/hold/flush control; flush wins over load.
module if_id_reg
    import ifetch_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [31:0]           i_pc,
    input  logic [31:0]           i_pc4,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [31:0]           o_pc,
    output logic [31:0]           o_pc4
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [31:0]           r_pc;
    logic [31:0]           r_pc4;

    // A flush only kills valid/instr; the PC fields keep their last value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= DATA_WIDTH'(NOP);
            r_pc    <= RESET_PC;
            r_pc4   <= RESET_PC + PC_STEP;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= DATA_WIDTH'(NOP);
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: PC, ROM word address, BOOT/RUN/HALT control, IF/ID capture.
// Optional macro IFETCH_ADDR_CHECK_EN adds fetch_err_o for out-of-window or misaligned fetches.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  if_id_valid_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [31:0]           if_id_pc_o,
    output logic [31:0]           if_id_pc4_o,
    output logic                  halted_o,
`ifdef IFETCH_ADDR_CHECK_EN
    output logic                  fetch_err_o,
`endif
    output fetch_state_t          dbg_state_o
);

`ifdef IFETCH_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam logic [33:0] WINDOW_BYTES = 34'(PC_STEP) << ADDR_WIDTH;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_pc4;
    logic [31:0]  w_offset;
    logic         w_load;
    logic         w_flush;
    logic         w_in_range;
    logic         w_redir_bad;
    logic         w_adv_bad;

    // ROM word 0 lives at RESET_PC; the index wraps with the window size.
    assign w_offset    = r_pc - RESET_PC;
    assign w_pc4       = r_pc + PC_STEP;
    assign w_in_range  = {2'b00, w_offset} < WINDOW_BYTES;
    assign w_redir_bad = CHECK_EN && (redirect_pc_i[1:0] != 2'b00);
    assign w_adv_bad   = CHECK_EN && !w_in_range;
    assign rom_addr_o  = w_offset[ADDR_WIDTH+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Priority in RUN: halt > redirect > stall > advance.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_flush     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (halt_i) begin
                    w_flush     = 1'b1;
                    w_state_nxt = HALT;
                end else if (redirect_i) begin
                    w_flush = 1'b1;
                    if (w_redir_bad) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt = align_word(redirect_pc_i);
                    end
                end else if (!stall_i) begin
                    if (w_adv_bad) begin
                        w_flush     = 1'b1;
                        w_state_nxt = HALT;
                    end else begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc4;
                    end
                end
            end
            HALT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_flush     = 1'b1;
                w_state_nxt = BOOT;
            end
        endcase
    end

`ifdef IFETCH_ADDR_CHECK_EN
    logic r_fetch_err;
    logic w_err_set;

    assign w_err_set = (r_state == RUN) && !halt_i &&
                       (redirect_i ? w_redir_bad : (!stall_i && w_adv_bad));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_err <= 1'b0;
        end else if (w_err_set) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err_o = r_fetch_err;
`endif

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_if_id (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (rom_data_i),
        .i_pc    (r_pc),
        .i_pc4   (w_pc4),
        .o_valid (if_id_valid_o),
        .o_instr (if_id_instr_o),
        .o_pc    (if_id_pc_o),
        .o_pc4   (if_id_pc4_o)
    );

    assign halted_o    = (r_state == HALT);
    assign dbg_state_o = r_state;

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage for the single-issue MIPS core; sits directly upstream of the combinational instruction ROM.
- Holds the PC and drives the ROM word address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, redirect (branch/jump/jal/jr) and halt (exit syscall) from downstream stages.

Parameters:
ADDR_WIDTH, 10, ROM word-address width; fetch window is 2^ADDR_WIDTH words.
DATA_WIDTH, 32, instruction width.
RESET_PC, 32'h0000_3000, byte address of ROM word 0; PC value after reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_i  in  1  hold PC and IF/ID register (load-use hazard).
redirect_i  in  1  take redirect_pc_i as next PC; flush IF/ID.
redirect_pc_i  in  32  redirect target byte address.
halt_i  in  1  one-cycle pulse from decode: exit syscall seen; stop fetching.
rom_addr_o  out  ADDR_WIDTH  ROM word address.
rom_data_i  in  DATA_WIDTH  ROM instruction, combinational from rom_addr_o.
if_id_valid_o  out  1  IF/ID holds a real instruction.
if_id_instr_o  out  DATA_WIDTH  fetched instruction; 0 (NOP) when invalid.
if_id_pc_o  out  32  byte PC of if_id_instr_o.
if_id_pc4_o  out  32  if_id_pc_o + 4 (jal link value).
halted_o  out  1  fetch is in HALT.

Behaviour:
- Reset (rst_n low, async):
  - pc = RESET_PC; state = BOOT.
  - if_id_valid_o = 0, if_id_instr_o = 0, if_id_pc_o = RESET_PC, if_id_pc4_o = RESET_PC+4, halted_o = 0.
  - Deassertion mid-operation is legal; all in-flight state is discarded.
- Address: rom_addr_o = (pc - RESET_PC)[ADDR_WIDTH+1:2], combinational from pc. PC wraps modulo 2^32; the ROM index wraps modulo 2^ADDR_WIDTH.
- FSM states and transitions:
  - BOOT: one cycle, IF/ID stays invalid, pc unchanged. Goes to RUN.
  - RUN: normal fetch. Goes to HALT on halt_i.
  - HALT: pc frozen, IF/ID valid = 0, halted_o = 1. Only reset leaves HALT.
- RUN, per cycle. Priority is halt_i > redirect_i > stall_i > advance.
  - halt_i: IF/ID invalidated (instr 0); pc held; next state HALT.
  - redirect_i: pc <= {redirect_pc_i[31:2], 2'b00}; IF/ID valid <= 0, instr <= 0. A redirect during a stall still wins.
  - stall_i only: pc and all IF/ID outputs hold.
  - advance: IF/ID <= {1, rom_data_i, pc, pc+4}; pc <= pc+4.
- Latency: an instruction at pc appears on if_id_* the cycle after pc is presented. After a redirect there is one bubble cycle before the target instruction is valid. There is no branch delay slot: the instruction after the branch/jump is killed by the flush.
- halt_i and redirect_i arriving in BOOT are ignored.
- halt_i arriving in HALT has no effect.

Optional Feature:
IFETCH_ADDR_CHECK_EN
- Defined:
  - Adds output fetch_err_o (1 bit, reset 0).
  - On advance, if pc is outside [RESET_PC, RESET_PC + 4*2^ADDR_WIDTH - 4], or on a redirect with redirect_pc_i[1:0] != 0: fetch_err_o <= 1 (sticky until reset), IF/ID valid <= 0, instr <= 0, and the FSM enters HALT on the next cycle.
- Undefined: no port; out-of-range addresses wrap silently; misaligned targets are silently truncated.

Decomposition:
- Package ifetch_pkg:
  - fetch state enum {BOOT, RUN, HALT}.
  - NOP constant 32'h0000_0000.
  - RESET_PC default.
  - PC_STEP = 4.
- One sub-module, if_id_reg: the IF/ID pipeline register with load/hold/flush controls, reused by the later ID/EX stage. PC, next-PC mux and FSM stay in ifetch_stage.

Test Plan:
- Reset then free-run, ROM holding words 0..2 = 20110001, 08000c05, 20110001:
  - Cycle 1 after reset: valid 0.
  - Cycles 2..4: if_id_pc_o = 3000, 3004, 3008; instr 20110001, 08000c05, 20110001; rom_addr_o = 0, 1, 2.
- stall_i high for 2 cycles with pc = 300C:
  - All if_id_* and rom_addr_o (3) held.
  - On release, the next fetch is 300C.
- redirect_i with target 00003014 while IF/ID holds pc 3004:
  - Next cycle: valid 0, instr 0.
  - Following cycle: if_id_pc_o = 3014, rom_addr_o was 5, pc4 = 3018.
- redirect_i and stall_i together (target 3050):
  - Redirect wins: bubble, then if_id_pc_o = 3050.
- halt_i pulse while pc = 304C:
  - halted_o = 1 next cycle, valid stays 0 thereafter.
  - Later redirect_i is ignored.
  - rst_n low asynchronously: outputs return to reset values immediately.
- With IFETCH_ADDR_CHECK_EN, ADDR_WIDTH 10, redirect to 00004000:
  - Flush, then fetch_err_o = 1, valid 0, halted_o = 1.
  - A redirect to 00003016 instead also sets fetch_err_o.
